// File: rtl/rtc_write_seq_if.sv
// rtl/rtc_write_seq_if.sv - control-side request and RTC bus signals of the write sequencer
interface rtc_write_seq_if;
    logic       start;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
    logic [7:0] data_a_RTC;
    logic       bus_oe;
    logic       AD;
    logic       CS;
    logic       RD;
    logic       WR;
    logic       busy;
    logic       done;

    modport master (
        output start, reg_addr, wr_data,
        input  data_a_RTC, bus_oe, AD, CS, RD, WR, busy, done
    );

    modport slave (
        input  start, reg_addr, wr_data,
        output data_a_RTC, bus_oe, AD, CS, RD, WR, busy, done
    );
endinterface

// File: rtl/rtc_write_seq.sv
// rtl/rtc_write_seq.sv - one RTC write: address phase, idle gap, data phase on the muxed AD bus
module rtc_write_seq #(
    parameter int T_SU  = 2,
    parameter int T_PW  = 4,
    parameter int T_H   = 2,
    parameter int T_GAP = 4
) (
    input  logic           clk,
    input  logic           reset,
    rtc_write_seq_if.slave bus
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_ADDR_SETUP = 4'd1;
    localparam logic [3:0] S_ADDR_PULSE = 4'd2;
    localparam logic [3:0] S_ADDR_HOLD  = 4'd3;
    localparam logic [3:0] S_GAP        = 4'd4;
    localparam logic [3:0] S_DATA_SETUP = 4'd5;
    localparam logic [3:0] S_DATA_PULSE = 4'd6;
    localparam logic [3:0] S_DATA_HOLD  = 4'd7;
    localparam logic [3:0] S_DONE       = 4'd8;

    // Counter reload values are duration-1; a zero duration still lasts one cycle.
    localparam logic [7:0] L_SU  = (T_SU  <= 1) ? 8'd0 : 8'(T_SU  - 1);
    localparam logic [7:0] L_PW  = (T_PW  <= 1) ? 8'd0 : 8'(T_PW  - 1);
    localparam logic [7:0] L_H   = (T_H   <= 1) ? 8'd0 : 8'(T_H   - 1);
    localparam logic [7:0] L_GAP = (T_GAP <= 1) ? 8'd0 : 8'(T_GAP - 1);

    logic [3:0] r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_addr;
    logic [7:0] r_data;
    logic [7:0] r_dout;
    logic       r_oe;
    logic       r_ad;
    logic       r_cs;
    logic       r_wr;
    logic       r_busy;
    logic       r_done;

    logic [3:0] w_next_state;
    logic [7:0] w_next_cnt;
    logic       w_accept;
    logic [7:0] w_addr;
    logic [7:0] w_data;
    logic [7:0] w_dout;
    logic       w_oe;
    logic       w_ad;
    logic       w_cs;
    logic       w_wr;
    logic       w_busy;
    logic       w_done;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_state = S_ADDR_SETUP;
                    w_next_cnt   = L_SU;
                    w_accept     = 1'b1;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
                w_next_cnt   = 8'd0;
            end
            default: begin
                if (r_cnt != 8'd0) begin
                    w_next_cnt = r_cnt - 8'd1;
                end else begin
                    case (r_state)
                        S_ADDR_SETUP: begin w_next_state = S_ADDR_PULSE; w_next_cnt = L_PW;  end
                        S_ADDR_PULSE: begin w_next_state = S_ADDR_HOLD;  w_next_cnt = L_H;   end
                        S_ADDR_HOLD:  begin w_next_state = S_GAP;        w_next_cnt = L_GAP; end
                        S_GAP:        begin w_next_state = S_DATA_SETUP; w_next_cnt = L_SU;  end
                        S_DATA_SETUP: begin w_next_state = S_DATA_PULSE; w_next_cnt = L_PW;  end
                        S_DATA_PULSE: begin w_next_state = S_DATA_HOLD;  w_next_cnt = L_H;   end
                        S_DATA_HOLD:  begin w_next_state = S_DONE;       w_next_cnt = 8'd0;  end
                        default:      begin w_next_state = S_IDLE;       w_next_cnt = 8'd0;  end
                    endcase
                end
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet change at the entry edge.
    assign w_addr = w_accept ? bus.reg_addr : r_addr;
    assign w_data = w_accept ? bus.wr_data  : r_data;

    always_comb begin
        w_ad   = 1'b1;
        w_cs   = 1'b1;
        w_wr   = 1'b1;
        w_oe   = 1'b0;
        w_dout = 8'h00;
        w_busy = (w_next_state != S_IDLE);
        w_done = (w_next_state == S_DONE);
        case (w_next_state)
            S_ADDR_SETUP, S_ADDR_HOLD: begin
                w_ad = 1'b0; w_cs = 1'b0; w_oe = 1'b1; w_dout = w_addr;
            end
            S_ADDR_PULSE: begin
                w_ad = 1'b0; w_cs = 1'b0; w_oe = 1'b1; w_dout = w_addr; w_wr = 1'b0;
            end
            S_DATA_SETUP, S_DATA_HOLD: begin
                w_cs = 1'b0; w_oe = 1'b1; w_dout = w_data;
            end
            S_DATA_PULSE: begin
                w_cs = 1'b0; w_oe = 1'b1; w_dout = w_data; w_wr = 1'b0;
            end
            default: begin
                w_ad = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_addr  <= 8'h00;
            r_data  <= 8'h00;
            r_dout  <= 8'h00;
            r_oe    <= 1'b0;
            r_ad    <= 1'b1;
            r_cs    <= 1'b1;
            r_wr    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) begin
                r_addr <= bus.reg_addr;
                r_data <= bus.wr_data;
            end
            r_dout  <= w_dout;
            r_oe    <= w_oe;
            r_ad    <= w_ad;
            r_cs    <= w_cs;
            r_wr    <= w_wr;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    assign bus.data_a_RTC = r_dout;
    assign bus.bus_oe     = r_oe;
    assign bus.AD         = r_ad;
    assign bus.CS         = r_cs;
    assign bus.RD         = 1'b1;
    assign bus.WR         = r_wr;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule

// File: tb/tb_rtc_write_seq.sv
// tb/tb_rtc_write_seq.sv - scoreboard bench: per-cycle expected bus vectors queued at start, popped by monitors
module tb_rtc_write_seq;

    typedef struct packed {
        logic [7:0] dout;
        logic       oe;
        logic       ad;
        logic       cs;
        logic       wr;
        logic       busy;
        logic       done;
    } vec_t;

    typedef struct {
        int   cyc;
        vec_t v;
    } exp_t;

    localparam vec_t IDLE_V = '{dout: 8'h00, oe: 1'b0, ad: 1'b1, cs: 1'b1, wr: 1'b1, busy: 1'b0, done: 1'b0};

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    rtc_write_seq_if if0 ();
    rtc_write_seq_if if1 ();

    rtc_write_seq dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    rtc_write_seq #(.T_SU(0), .T_PW(1), .T_H(0), .T_GAP(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_vec(input string nm, input vec_t act, input vec_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got dout=%h oe=%b ad=%b cs=%b wr=%b busy=%b done=%b want dout=%h oe=%b ad=%b cs=%b wr=%b busy=%b done=%b",
                     nm, cyc, act.dout, act.oe, act.ad, act.cs, act.wr, act.busy, act.done,
                     exp.dout, exp.oe, exp.ad, exp.cs, exp.wr, exp.busy, exp.done);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    // Expected outputs in cycle k (1-based) after the accepting edge, for effective phase lengths.
    function automatic vec_t exp_at(input int k, input int su, input int pw, input int h, input int gap,
                                    input logic [7:0] a, input logic [7:0] d);
        vec_t v;
        int b1, b2, b3, b4, b5, b6, b7;
        b1 = su; b2 = b1 + pw; b3 = b2 + h; b4 = b3 + gap;
        b5 = b4 + su; b6 = b5 + pw; b7 = b6 + h;
        v = '{dout: 8'h00, oe: 1'b0, ad: 1'b1, cs: 1'b1, wr: 1'b1, busy: 1'b1, done: 1'b0};
        if (k <= b3) begin
            v.dout = a; v.oe = 1'b1; v.ad = 1'b0; v.cs = 1'b0;
            v.wr = (k > b1 && k <= b2) ? 1'b0 : 1'b1;
        end else if (k <= b4) begin
            v.ad = 1'b1;
        end else if (k <= b7) begin
            v.dout = d; v.oe = 1'b1; v.cs = 1'b0;
            v.wr = (k > b5 && k <= b6) ? 1'b0 : 1'b1;
        end else begin
            v.done = 1'b1;
        end
        return v;
    endfunction

    function automatic vec_t act0();
        return '{dout: if0.data_a_RTC, oe: if0.bus_oe, ad: if0.AD, cs: if0.CS, wr: if0.WR, busy: if0.busy, done: if0.done};
    endfunction

    function automatic vec_t act1();
        return '{dout: if1.data_a_RTC, oe: if1.bus_oe, ad: if1.AD, cs: if1.CS, wr: if1.WR, busy: if1.busy, done: if1.done};
    endfunction

    task automatic push_txn(input int unit, input int base, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        int su, pw, h, gap, n;
        if (unit == 0) begin su = 2; pw = 4; h = 2; gap = 4; end
        else begin su = 1; pw = 1; h = 1; gap = 1; end
        n = 2 * (su + pw + h) + gap + 1;
        for (int k = 1; k <= n; k++) begin
            e.cyc = base + k;
            e.v   = exp_at(k, su, pw, h, gap, a, d);
            if (unit == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    // Drives a one-cycle start just after a posedge; returns the cycle count at drive time.
    task automatic issue(input int unit, input logic [7:0] a, input logic [7:0] d, output int base);
        @(posedge clk); #1;
        if (unit == 0) begin if0.start = 1'b1; if0.reg_addr = a; if0.wr_data = d; end
        else begin if1.start = 1'b1; if1.reg_addr = a; if1.wr_data = d; end
        base = cyc;
        push_txn(unit, base, a, d);
        @(posedge clk); #1;
        if0.start = 1'b0;
        if1.start = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        chk_int("rd0_high", int'(if0.RD), 1);
        if (if0.busy || if0.done) begin
            if (q0.size() == 0) begin
                chk_vec("dut0_unexpected", act0(), IDLE_V);
            end else begin
                e = q0.pop_front();
                chk_int("dut0_cycle", cyc, e.cyc);
                chk_vec("dut0_txn", act0(), e.v);
            end
        end else begin
            chk_vec("dut0_idle", act0(), IDLE_V);
        end
        if (if1.busy || if1.done) begin
            if (q1.size() == 0) begin
                chk_vec("dut1_unexpected", act1(), IDLE_V);
            end else begin
                e = q1.pop_front();
                chk_int("dut1_cycle", cyc, e.cyc);
                chk_vec("dut1_txn", act1(), e.v);
            end
        end else begin
            chk_vec("dut1_idle", act1(), IDLE_V);
        end
    end

    initial begin
        int base;
        if0.start = 1'b0; if0.reg_addr = 8'h00; if0.wr_data = 8'h00;
        if1.start = 1'b0; if1.reg_addr = 8'h00; if1.wr_data = 8'h00;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(posedge clk);

        issue(0, 8'h21, 8'h59, base);
        repeat (25) @(posedge clk);

        // Start pulse and new inputs mid-transaction must not disturb the latched write.
        issue(0, 8'h22, 8'h12, base);
        repeat (9) @(posedge clk);
        #1 if0.reg_addr = 8'h00; if0.wr_data = 8'hEE; if0.start = 1'b1;
        @(posedge clk); #1 if0.start = 1'b0;
        repeat (15) @(posedge clk);

        // Start held high: second transaction accepted in the single IDLE cycle after DONE.
        @(posedge clk); #1;
        if0.start = 1'b1; if0.reg_addr = 8'h23; if0.wr_data = 8'h08;
        base = cyc;
        push_txn(0, base, 8'h23, 8'h08);
        push_txn(0, base + 22, 8'h23, 8'h08);
        repeat (23) @(posedge clk);
        #1 if0.start = 1'b0;
        repeat (30) @(posedge clk);

        // Reset asserted in DATA_PULSE, between clock edges.
        issue(0, 8'h5A, 8'hA5, base);
        repeat (15) @(posedge clk);
        #1 reset = 1'b1;
        q0.delete();
        #1;
        chk_int("rst_async_wr", int'(if0.WR), 1);
        chk_int("rst_async_cs", int'(if0.CS), 1);
        chk_int("rst_async_oe", int'(if0.bus_oe), 0);
        chk_int("rst_async_busy", int'(if0.busy), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (30) @(posedge clk);
        issue(0, 8'h3C, 8'hC3, base);
        repeat (25) @(posedge clk);

        issue(1, 8'h77, 8'h88, base);
        repeat (12) @(posedge clk);

        chk_int("q0_drained", q0.size(), 0);
        chk_int("q1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rtc_write_seq.md
Name: rtc_write_seq

Overview:
- Write-side sequencer for the external RTC's multiplexed address/data bus (AD, CS, RD, WR strobes, all active low except AD).
- Complements the existing read path: it performs one complete write transaction.
  - Address phase with AD low.
  - Bus-idle gap.
  - Data phase with AD high.
- Target register and data byte are supplied by the control FSM.
- Drives the shared 8-bit bus through an output-enable; top level muxes strobes with the read path (read path idle whenever busy=1).

Parameters:
- T_SU, 2, setup cycles (CS/AD/bus valid before WR falls), per phase
- T_PW, 4, WR low pulse width in cycles, per phase
- T_H, 2, hold cycles after WR rises (CS/AD/bus held), per phase
- T_GAP, 4, cycles with all strobes inactive and bus released between address and data phases

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- reg_addr  in  8  RTC register address, latched on accepted start
- wr_data  in  8  data byte, latched on accepted start
- data_a_RTC  out  8  value driven onto RTC bus when bus_oe=1
- bus_oe  out  1  1 = this block drives the RTC bus
- AD  out  1  0 = address phase, 1 = data phase / idle
- CS  out  1  chip select, active low
- RD  out  1  read strobe, held 1 permanently
- WR  out  1  write strobe, active low
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at end of transaction

Behaviour:
- One clock (clk); reset is asynchronous and active-high. All outputs are registered; no combinational path from any input to any output.
- Reset values, also the idle values:
  - AD=1, CS=1, RD=1, WR=1
  - bus_oe=0, data_a_RTC=0x00
  - busy=0, done=0
  - state=IDLE, phase counter=0
- Start acceptance: start=1 in IDLE at edge E latches reg_addr/wr_data. State enters ADDR_SETUP at E; outputs change from E onward.
- FSM states, each lasting its parameter count of cycles via an 8-bit down-counter:
  - IDLE → ADDR_SETUP
  - ADDR_SETUP (T_SU) → ADDR_PULSE (T_PW) → ADDR_HOLD (T_H)
  - → GAP (T_GAP)
  - → DATA_SETUP (T_SU) → DATA_PULSE (T_PW) → DATA_HOLD (T_H)
  - → DONE (1 cycle) → IDLE
- Outputs per state:
  - ADDR_SETUP/ADDR_HOLD: AD=0, CS=0, WR=1, bus_oe=1, data_a_RTC=latched addr.
  - ADDR_PULSE: same as ADDR_SETUP/ADDR_HOLD, but WR=0.
  - GAP: AD=1, CS=1, WR=1, bus_oe=0, data_a_RTC=0x00.
  - DATA_SETUP/DATA_HOLD: AD=1, CS=0, WR=1, bus_oe=1, data_a_RTC=latched data.
  - DATA_PULSE: same as DATA_SETUP/DATA_HOLD, but WR=0.
  - DONE: all idle values, done=1.
- busy=1 in every state except IDLE, including DONE.
- Latency with defaults: busy rises 1 cycle after start; done occurs in cycle 2*(T_SU+T_PW+T_H)+T_GAP+1 = 21 after the accepting edge.
- WR never falls in the same cycle CS falls or AD changes; AD never changes while CS=0.
- Parameter value 0 is treated as 1 (every phase lasts at least 1 cycle).
- start ignored while busy, including in DONE. A start held high through DONE is accepted on the first IDLE cycle, giving back-to-back transactions with exactly one IDLE cycle between them.
- reg_addr/wr_data changes after acceptance have no effect on the transaction in flight.
- Reset mid-transaction: all outputs go to idle values immediately (asynchronous). No done pulse; the latched transaction is discarded.
- RD is constant 1; the block never reads.

Test Plan:
- Reset then idle: reset=1 for 3 cycles, release → AD=CS=RD=WR=1, bus_oe=0, busy=done=0 steady for 20 cycles.
- Single write, defaults: start 1 cycle with reg_addr=0x21, wr_data=0x59 → data_a_RTC=0x21 with AD=0/CS=0 for 8 cycles, WR=0 on cycles 3-6; CS=1/bus_oe=0 for cycles 9-12; data_a_RTC=0x59 with AD=1/CS=0 on cycles 13-20, WR=0 on cycles 15-18; done=1 only on cycle 21; busy=1 cycles 1-21.
- Input change and start while busy: change reg_addr to 0x00 and pulse start at cycle 10 of a write to 0x22/0x12 → bus still shows 0x12 in data phase; exactly one done pulse.
- Back-to-back: hold start=1 with 0x23/0x08 → second transaction's ADDR_SETUP begins 2 cycles after the first done (one IDLE cycle between).
- Reset mid-op: assert reset during DATA_PULSE → WR=1, CS=1, bus_oe=0 without waiting for a clock edge; no done pulse; next start runs a full 21-cycle transaction.
- Parameter edge: T_SU=0, T_PW=1, T_H=0, T_GAP=1 → each phase lasts 1 cycle; done on cycle 8.
